// File: rtl/rot_word_serializer.sv
// ---------------------------------------------------------------------------
// rot_word_serializer
//
// Purpose:
//   Takes each rotated parallel word from the upstream rotator through a
//   valid/ready handshake. It sends the word out one bit per transfer on a
//   serial valid/ready stream. The final bit of each word is flagged, and
//   completed words are counted modulo 256. A new word can be loaded at the
//   same edge as the last-bit transfer, so back-to-back words stream without
//   an idle cycle.
//
// Parameters:
//   WIDTH      parallel word width (>= 2)
//   MSB_FIRST  0: in_data[0] goes out first, 1: in_data[WIDTH-1] goes out first
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    parallel word from the rotator
//   in_valid   in_data is valid
//   in_ready   word is accepted at this edge (combinational on ser_ready)
//   ser_out    current serial bit
//   ser_valid  ser_out is valid
//   ser_ready  downstream consumes ser_out at this edge
//   ser_last   ser_out is the final bit of the current word
//   busy       a word is loaded and not yet fully transferred
//   word_cnt   completed words, modulo 256
// ---------------------------------------------------------------------------
module rot_word_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy,
    output logic [7:0]       word_cnt
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_bcnt;
    logic [7:0]       r_wordCnt;

    logic             w_shifting;
    logic             w_lastXfer;
    logic             w_accept;
    logic [WIDTH-1:0] w_shifted;

    // The shift register always presents the next bit at its output end.
    // Every transfer moves the contents one place toward that end and fills
    // the vacated end with zero.
    assign w_shifted = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0}
                                 : {1'b0, r_sreg[WIDTH-1:1]};

    assign w_shifting = (r_state == ST_SHIFT);
    assign w_lastXfer = w_shifting && ser_ready && (r_bcnt == LAST_IDX);

    // Ready is combinational on ser_ready, so the next word can be taken at
    // the same edge the last bit leaves. That edge shared by both events is
    // the zero-bubble reload.
    assign in_ready = !rst && ((r_state == ST_IDLE) || w_lastXfer);
    assign w_accept = in_valid && in_ready;

    assign ser_out   = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];
    assign ser_valid = w_shifting;
    assign ser_last  = w_shifting && (r_bcnt == LAST_IDX);
    assign busy      = w_shifting;
    assign word_cnt  = r_wordCnt;

    // Control and datapath state. Reset wins over everything. A load (from
    // idle or as a reload on the last bit) restarts the bit counter. A
    // plain last-bit transfer clears the shift register so ser_out reads
    // zero while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sreg    <= '0;
            r_bcnt    <= '0;
            r_wordCnt <= 8'd0;
        end else begin
            if (w_lastXfer) begin
                r_wordCnt <= r_wordCnt + 8'd1;
            end

            if (w_accept) begin
                r_sreg  <= in_data;
                r_bcnt  <= '0;
                r_state <= ST_SHIFT;
            end else if (w_lastXfer) begin
                r_sreg  <= '0;
                r_bcnt  <= '0;
                r_state <= ST_IDLE;
            end else if (w_shifting && ser_ready) begin
                r_sreg <= w_shifted;
                r_bcnt <= r_bcnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rot_word_serializer.sv
// ---------------------------------------------------------------------------
// tb_rot_word_serializer
//
// Drives two serializers (LSB-first and MSB-first) with the same stimulus.
// Each cycle it compares all of their outputs against a word-level model.
// The model holds the current word, the index of the bit being presented,
// and the number of bits still owed downstream.
// ---------------------------------------------------------------------------
module tb_rot_word_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] inData;
    logic         inValid;
    logic         serReady;

    logic         inReadyL, serOutL, serValidL, serLastL, busyL;
    logic [7:0]   wordCntL;
    logic         inReadyM, serOutM, serValidM, serLastM, busyM;
    logic [7:0]   wordCntM;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state
    logic [W-1:0] mWord = '0;
    int           mIdx  = 0;
    int           mLeft = 0;
    logic [7:0]   mCnt  = 8'd0;

    always #5 clk = ~clk;

    rot_word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid),
        .in_ready(inReadyL), .ser_out(serOutL), .ser_valid(serValidL),
        .ser_ready(serReady), .ser_last(serLastL), .busy(busyL),
        .word_cnt(wordCntL)
    );

    rot_word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
        .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid),
        .in_ready(inReadyM), .ser_out(serOutM), .ser_valid(serValidM),
        .ser_ready(serReady), .ser_last(serLastM), .busy(busyM),
        .word_cnt(wordCntM)
    );

    // One comparison: count it and report a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Compare both DUTs against the model's view of the current cycle.
    task automatic compareAll();
        logic       expValid, expLast, expReady, expBitL, expBitM;
        expValid = (mLeft > 0);
        expLast  = (mLeft == 1);
        expBitL  = expValid ? mWord[mIdx] : 1'b0;
        expBitM  = expValid ? mWord[W-1-mIdx] : 1'b0;
        expReady = !rst && ((mLeft == 0) || ((mLeft == 1) && serReady));
        checkOutput("inReadyL",  inReadyL,  expReady);
        checkOutput("serOutL",   serOutL,   expBitL);
        checkOutput("serValidL", serValidL, expValid);
        checkOutput("serLastL",  serLastL,  expLast);
        checkOutput("busyL",     busyL,     expValid);
        checkOutput("wordCntL",  wordCntL,  mCnt);
        checkOutput("inReadyM",  inReadyM,  expReady);
        checkOutput("serOutM",   serOutM,   expBitM);
        checkOutput("serValidM", serValidM, expValid);
        checkOutput("serLastM",  serLastM,  expLast);
        checkOutput("busyM",     busyM,     expValid);
        checkOutput("wordCntM",  wordCntM,  mCnt);
    endtask

    // Advance the model across one clock edge using the inputs of the cycle.
    task automatic updateModel();
        logic accept;
        accept = !rst && inValid && ((mLeft == 0) || ((mLeft == 1) && serReady));
        if (rst) begin
            mLeft = 0;
            mIdx  = 0;
            mCnt  = 8'd0;
        end else begin
            if ((mLeft > 0) && serReady) begin
                mLeft--;
                mIdx++;
                if (mLeft == 0) mCnt++;
            end
            if (accept) begin
                mWord = inData;
                mIdx  = 0;
                mLeft = W;
            end
        end
    endtask

    // One full cycle: drive at the falling edge, check, then cross the edge.
    task automatic applyStimulus(input logic r, input logic [W-1:0] d,
                                 input logic v, input logic sr);
        @(negedge clk);
        rst      = r;
        inData   = d;
        inValid  = v;
        serReady = sr;
        #1;
        compareAll();
        @(posedge clk);
        updateModel();
    endtask

    initial begin
        rst      = 1'b1;
        inData   = '0;
        inValid  = 1'b0;
        serReady = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, then 8'hA5 with ser_ready held high
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'hA5, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("a5WordCnt", wordCntL, 32'd1);

        // 8'h81 then 8'h3C back-to-back with in_valid held high
        applyStimulus(1'b0, 8'h81, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h3C, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // 8'hF0 with ser_ready pattern 1,0,0,1 repeating
        applyStimulus(1'b0, 8'hF0, 1'b1, 1'b1);
        for (int i = 0; i < 24; i++)
            applyStimulus(1'b0, 8'h00, 1'b0, ((i % 4) == 0) || ((i % 4) == 3));

        // Reset after three bits of 8'hFF, then 8'h01 from bit 0
        applyStimulus(1'b0, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h01, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Word ignored when in_valid pulses mid-word
        applyStimulus(1'b0, 8'hAA, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h55, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // 256 consecutive words from a cleared counter: it must wrap to 0
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i <= 256 * W; i++)
            applyStimulus(1'b0, 8'($urandom), (i < 256 * W), 1'b1);
        #2;
        checkOutput("wrapWordCnt", wordCntL, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++)
            applyStimulus(($urandom_range(0, 63) == 0), 8'($urandom),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checkCount, errorCount);
        $finish;
    end

endmodule
